traffic_display_scanner: RTL and testbench

//  Consumer side of the intersection controller's status outputs. Takes the four BCD

---
 rtl/traffic_display_scanner_pkg.sv | 38 +++
 rtl/traffic_display_scanner_bcd7seg.sv | 28 ++
 rtl/traffic_display_scanner.sv | 144 ++++++++++++++
 tb/tb_traffic_display_scanner.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/traffic_display_scanner_pkg.sv
// Shared segment patterns, slot indices and the frame snapshot type for the status display.
// The controller top level reuses the SEG_* constants.
package traffic_display_scanner_pkg;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Slot value equals the DIG bit index it enables.
    localparam logic [1:0] SLOT_AH = 2'd3;
    localparam logic [1:0] SLOT_AL = 2'd2;
    localparam logic [1:0] SLOT_BH = 2'd1;
    localparam logic [1:0] SLOT_BL = 2'd0;

    typedef struct packed {
        logic [3:0] a_h;
        logic [3:0] a_l;
        logic [3:0] b_h;
        logic [3:0] b_l;
        logic       a_light;
        logic       b_light;
    } snap_t;

    function automatic logic illegal_pair(input snap_t s);
        return s.a_light == s.b_light;
    endfunction

endpackage

// File: rtl/traffic_display_scanner_bcd7seg.sv
// Combinational BCD to 7-segment decoder with optional zero blanking.
// Values 10-15 decode to a dash.
module bcd7seg
    import traffic_display_scanner_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_zero_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        unique case (bcd_i)
            4'd0:    seg_o = blank_zero_i ? SEG_BLANK : SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/traffic_display_scanner.sv
// Scans the intersection countdown onto a 4-digit multiplexed display and drives the lamps,
// showing a blinking-red fault display whenever the frame snapshot holds an illegal light pair.
module traffic_display_scanner
    import traffic_display_scanner_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DIV_W    = 10
) (
    input  logic       CLK,
    input  logic       R,
    input  logic [3:0] A_Time_H,
    input  logic [3:0] A_Time_L,
    input  logic [3:0] B_Time_H,
    input  logic [3:0] B_Time_L,
    input  logic       A_Light,
    input  logic       B_Light,
    output logic [6:0] SEG,
    output logic [3:0] DIG,
    output logic       A_RED,
    output logic       A_GRN,
    output logic       B_RED,
    output logic       B_GRN,
    output logic       FAULT
);

    logic [DIV_W-1:0] presc_q, presc_d;
    logic [1:0]       slot_q, slot_d;
    snap_t            snap_q, snap_d;
    logic             first_q, first_d;
    logic             fault_q, fault_d;
    logic             blink_q, blink_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       dig_q, dig_d;
    logic [3:0]       lamp_q, lamp_d; // {a_red, a_grn, b_red, b_grn}

    snap_t      in_snap;
    snap_t      disp_snap;
    logic [1:0] disp_slot;
    logic       disp_fault;
    logic       tick;
    logic       capture;
    logic [3:0] digit;
    logic       blank_zero;
    logic [6:0] dec_seg;

    always_comb begin
        in_snap = '{a_h: A_Time_H, a_l: A_Time_L, b_h: B_Time_H, b_l: B_Time_L,
                    a_light: A_Light, b_light: B_Light};

        tick    = (presc_q == DIV_W'(SCAN_DIV - 1));
        presc_d = tick ? '0 : presc_q + DIV_W'(1);
        capture = first_q | (tick & (slot_q == SLOT_BL));

        first_d = 1'b0;
        slot_d  = slot_q;
        snap_d  = snap_q;
        fault_d = fault_q;
        blink_d = blink_q;

        if (first_q) begin
            slot_d = SLOT_AH;
        end else if (tick) begin
            slot_d = slot_q - 2'd1;
        end

        if (capture) begin
            snap_d  = in_snap;
            fault_d = illegal_pair(in_snap);
            blink_d = fault_d ? ~blink_q : 1'b0;
        end

        if (fault_d) begin
            lamp_d = {blink_d, 1'b0, blink_d, 1'b0};
        end else begin
            lamp_d = {~snap_d.a_light, snap_d.a_light, ~snap_d.b_light, snap_d.b_light};
        end
    end

    // The first cycle after reset shows the snapshot being captured so DIG asserts at once.
    always_comb begin
        disp_snap  = first_q ? in_snap : snap_q;
        disp_slot  = first_q ? SLOT_AH : slot_q;
        disp_fault = first_q ? illegal_pair(in_snap) : fault_q;

        digit = disp_snap.b_l;
        unique case (disp_slot)
            SLOT_AH: digit = disp_snap.a_h;
            SLOT_AL: digit = disp_snap.a_l;
            SLOT_BH: digit = disp_snap.b_h;
            SLOT_BL: digit = disp_snap.b_l;
            default: digit = disp_snap.b_l;
        endcase
        blank_zero = (disp_slot == SLOT_AH) || (disp_slot == SLOT_BH);
    end

    bcd7seg u_bcd7seg (
        .bcd_i        (digit),
        .blank_zero_i (blank_zero),
        .seg_o        (dec_seg)
    );

    // A tick blanks the digit enables for one cycle so the old segments never ghost.
    always_comb begin
        dig_d = 4'b0000;
        seg_d = SEG_BLANK;
        if (!tick) begin
            dig_d = 4'b0001 << disp_slot;
            seg_d = disp_fault ? SEG_DASH : dec_seg;
        end
    end

    always_ff @(posedge CLK) begin
        if (!R) begin
            presc_q <= '0;
            slot_q  <= SLOT_BL;
            snap_q  <= '0;
            first_q <= 1'b1;
            fault_q <= 1'b0;
            blink_q <= 1'b0;
            seg_q   <= SEG_BLANK;
            dig_q   <= 4'b0000;
            lamp_q  <= 4'b0000;
        end else begin
            presc_q <= presc_d;
            slot_q  <= slot_d;
            snap_q  <= snap_d;
            first_q <= first_d;
            fault_q <= fault_d;
            blink_q <= blink_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            lamp_q  <= lamp_d;
        end
    end

    assign SEG   = seg_q;
    assign DIG   = dig_q;
    assign A_RED = lamp_q[3];
    assign A_GRN = lamp_q[2];
    assign B_RED = lamp_q[1];
    assign B_GRN = lamp_q[0];
    assign FAULT = fault_q;

endmodule

// File: tb/tb_traffic_display_scanner.sv
// Directed bench for traffic_display_scanner with SCAN_DIV=4: 16-cycle frames, capture at
// frame cycle 15, DIG pattern 1000 x3, gap, 0100 x3, gap, 0010 x3, gap, 0001 x3, gap.
module tb_traffic_display_scanner;

    logic       CLK = 1'b0;
    logic       R = 1'b0;
    logic [3:0] A_Time_H = '0;
    logic [3:0] A_Time_L = '0;
    logic [3:0] B_Time_H = '0;
    logic [3:0] B_Time_L = '0;
    logic       A_Light = 1'b0;
    logic       B_Light = 1'b0;
    logic [6:0] SEG;
    logic [3:0] DIG;
    logic       A_RED, A_GRN, B_RED, B_GRN, FAULT;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    traffic_display_scanner #(
        .SCAN_DIV (4),
        .DIV_W    (2)
    ) dut (
        .CLK      (CLK),
        .R        (R),
        .A_Time_H (A_Time_H),
        .A_Time_L (A_Time_L),
        .B_Time_H (B_Time_H),
        .B_Time_L (B_Time_L),
        .A_Light  (A_Light),
        .B_Light  (B_Light),
        .SEG      (SEG),
        .DIG      (DIG),
        .A_RED    (A_RED),
        .A_GRN    (A_GRN),
        .B_RED    (B_RED),
        .B_GRN    (B_GRN),
        .FAULT    (FAULT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic goto(input int target);
        while (cyc < target) step();
    endtask

    task automatic set_inputs(input logic [3:0] ah, input logic [3:0] al, input logic [3:0] bh,
                              input logic [3:0] bl, input logic la, input logic lb);
        A_Time_H = ah;
        A_Time_L = al;
        B_Time_H = bh;
        B_Time_L = bl;
        A_Light  = la;
        B_Light  = lb;
    endtask

    // Expected lamps as {a_red, a_grn, b_red, b_grn}.
    task automatic chk_lamps(input string tag, input logic [3:0] exp, input logic exp_fault);
        chk({tag, "_lamps"}, 32'({A_RED, A_GRN, B_RED, B_GRN}), 32'(exp));
        chk({tag, "_fault"}, 32'(FAULT), 32'(exp_fault));
    endtask

    task automatic check_frame(input string tag, input int base, input logic [6:0] s3,
                               input logic [6:0] s2, input logic [6:0] s1, input logic [6:0] s0);
        goto(base);
        chk({tag, "_dig_ah"}, 32'(DIG), 32'h8);
        chk({tag, "_seg_ah"}, 32'(SEG), 32'(s3));
        goto(base + 3);
        chk({tag, "_gap"}, 32'(DIG), 32'h0);
        goto(base + 4);
        chk({tag, "_dig_al"}, 32'(DIG), 32'h4);
        chk({tag, "_seg_al"}, 32'(SEG), 32'(s2));
        goto(base + 8);
        chk({tag, "_dig_bh"}, 32'(DIG), 32'h2);
        chk({tag, "_seg_bh"}, 32'(SEG), 32'(s1));
        goto(base + 12);
        chk({tag, "_dig_bl"}, 32'(DIG), 32'h1);
        chk({tag, "_seg_bl"}, 32'(SEG), 32'(s0));
    endtask

    initial begin
        // Reset with random inputs.
        R = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_inputs(4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)),
                       4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)));
            step();
        end
        chk("rst_seg", 32'(SEG), 32'h0);
        chk("rst_dig", 32'(DIG), 32'h0);
        chk_lamps("rst", 4'b0000, 1'b0);

        // A=25, B=07, A green.
        set_inputs(4'd2, 4'd5, 4'd0, 4'd7, 1'b1, 1'b0);
        R   = 1'b1;
        cyc = -1;
        step();
        chk_lamps("f0", 4'b0110, 1'b0);
        check_frame("f0", 0, 7'h5B, 7'h6D, 7'h00, 7'h07);

        // Mid-frame change to A=24, B=03 must wait for the next frame.
        check_frame("f1a", 16, 7'h5B, 7'h6D, 7'h00, 7'h07);
        goto(22);
        set_inputs(4'd2, 4'd4, 4'd0, 4'd3, 1'b1, 1'b0);
        goto(28);
        chk("f1_held_bl", 32'(SEG), 32'h07);
        check_frame("f2", 32, 7'h5B, 7'h66, 7'h00, 7'h4F);

        // Both green: fault from the frame after capture, red lamps blink 1,0,1.
        goto(40);
        set_inputs(4'd2, 4'd4, 4'd0, 4'd3, 1'b1, 1'b1);
        goto(46);
        chk("pre_fault", 32'(FAULT), 32'h0);
        goto(47);
        chk("fault_edge", 32'(FAULT), 32'h1);
        check_frame("f3", 48, 7'h40, 7'h40, 7'h40, 7'h40);
        goto(48);
        chk_lamps("f3", 4'b1010, 1'b1);
        goto(64);
        chk_lamps("f4", 4'b0000, 1'b1);
        goto(80);
        chk_lamps("f5", 4'b1010, 1'b1);
        goto(84);
        set_inputs(4'd2, 4'd4, 4'd0, 4'd3, 1'b0, 1'b1);
        goto(96);
        chk_lamps("f6", 4'b1001, 1'b0);
        check_frame("f6", 96, 7'h5B, 7'h66, 7'h00, 7'h4F);

        // Re-entering fault starts blink at 1 again.
        goto(100);
        set_inputs(4'd2, 4'd4, 4'd0, 4'd3, 1'b0, 1'b0);
        goto(112);
        chk_lamps("f7", 4'b1010, 1'b1);

        // Out-of-range units digit shows a dash.
        goto(116);
        set_inputs(4'd2, 4'hC, 4'd0, 4'd7, 1'b1, 1'b0);
        check_frame("f8", 128, 7'h5B, 7'h40, 7'h00, 7'h07);
        chk_lamps("f8", 4'b0110, 1'b0);

        // A=00 blanks only the tens digit; B=17 shows its tens digit.
        goto(136);
        set_inputs(4'd0, 4'd0, 4'd1, 4'd7, 1'b1, 1'b0);
        goto(144);
        chk("f9_dig_ah", 32'(DIG), 32'h8);
        chk("f9_seg_ah", 32'(SEG), 32'h00);
        goto(148);
        chk("f9_seg_al", 32'(SEG), 32'h3F);

        // Reset at frame cycle 9 clears everything at the next edge.
        goto(152);
        chk("f9_seg_bh", 32'(SEG), 32'h06);
        goto(153);
        R = 1'b0;
        step();
        chk("mid_rst_seg", 32'(SEG), 32'h0);
        chk("mid_rst_dig", 32'(DIG), 32'h0);
        chk_lamps("mid_rst", 4'b0000, 1'b0);
        set_inputs(4'd9, 4'd3, 4'd0, 4'd8, 1'b0, 1'b1);
        step();
        R   = 1'b1;
        cyc = -1;
        step();
        chk_lamps("restart", 4'b1001, 1'b0);
        check_frame("restart", 0, 7'h6F, 7'h4F, 7'h00, 7'h7F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
